// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA raster timing generator with pixel-memory addressing, a
//            latency-matched sync/blank pipeline and built-in test patterns.
// Ports    : clk, rst (async, active low), en (timing enable)
//            mode (0 memory, 1 colour bars, 2 solid, 3 grid), solid_rgb
//            h_addr/v_addr -> pixel memory, rd_data <- pixel memory {R,G,B}
//            hsync, vsync, valid (blank_n), vga_r/g/b
//            frame_start, line_start (one-clk pulses on first active pixel)
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   RD_LAT   = 1,
  parameter int   CLK_DIV  = 1,
  parameter int   AW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [23:0]   solid_rgb,
  output logic [AW-1:0] h_addr,
  output logic [AW-1:0] v_addr,
  input  logic [23:0]   rd_data,
  output logic          hsync,
  output logic          vsync,
  output logic          valid,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          frame_start,
  output logic          line_start
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_HW      = $clog2(c_H_TOTAL);
  localparam int c_VW      = $clog2(c_V_TOTAL);
  localparam int c_DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_PW      = 3 + c_HW + c_VW;

  localparam logic [c_DW-1:0] c_DIV_LAST  = c_DW'(CLK_DIV - 1);
  localparam logic [c_HW-1:0] c_H_LAST    = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_VW-1:0] c_V_LAST    = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_HW-1:0] c_H_ACT     = c_HW'(H_ACTIVE);
  localparam logic [c_VW-1:0] c_V_ACT     = c_VW'(V_ACTIVE);
  localparam logic [c_HW-1:0] c_HS_START  = c_HW'(H_ACTIVE + H_FP);
  localparam logic [c_HW-1:0] c_HS_END    = c_HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [c_VW-1:0] c_VS_START  = c_VW'(V_ACTIVE + V_FP);
  localparam logic [c_VW-1:0] c_VS_END    = c_VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [c_DW-1:0] r_div;
  logic [c_HW-1:0] r_h_cnt;
  logic [c_VW-1:0] r_v_cnt;
  logic            w_pix_ce;

  // Divider counts only while enabled, so a paused pixel resumes with the
  // remainder of its CLK_DIV window rather than restarting it.
  assign w_pix_ce = en && (r_div == c_DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_ce) begin
      if (r_h_cnt == c_H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + c_VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + c_HW'(1);
      end
    end
  end

  logic w_raw_act;
  logic w_raw_hs;
  logic w_raw_vs;
  logic w_origin;

  assign w_raw_act = en && (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
  assign w_raw_hs  = (r_h_cnt >= c_HS_START) && (r_h_cnt <= c_HS_END);
  assign w_raw_vs  = (r_v_cnt >= c_VS_START) && (r_v_cnt <= c_VS_END);
  assign w_origin  = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign h_addr    = w_raw_act ? AW'(r_h_cnt) : '0;
  assign v_addr    = w_raw_act ? AW'(r_v_cnt) : '0;

  // Sync flags travel the pipeline as "asserted" bits so a cleared stage
  // always means an idle sync level, whatever the output polarity.
  logic [c_PW-1:0] w_raw_pkt;
  logic [c_PW-1:0] w_dly_pkt;

  assign w_raw_pkt = {w_raw_hs, w_raw_vs, w_raw_act, r_h_cnt, r_v_cnt};

  if (RD_LAT == 0) begin : g_no_lat
    assign w_dly_pkt = w_raw_pkt;
  end else begin : g_lat
    logic [c_PW-1:0] r_pipe [RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
      end else if (w_pix_ce) begin
        r_pipe[0] <= w_raw_pkt;
        for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign w_dly_pkt = r_pipe[RD_LAT-1];
  end

  logic            w_d_hs;
  logic            w_d_vs;
  logic            w_d_act;
  logic [c_HW-1:0] w_d_h;
  logic [c_VW-1:0] w_d_v;

  assign w_d_hs  = w_dly_pkt[c_PW-1];
  assign w_d_vs  = w_dly_pkt[c_PW-2];
  assign w_d_act = w_dly_pkt[c_PW-3];
  assign w_d_h   = w_dly_pkt[c_HW+c_VW-1 -: c_HW];
  assign w_d_v   = w_dly_pkt[c_VW-1:0];

  logic [1:0]  r_mode;
  logic [23:0] r_solid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode  <= 2'd0;
      r_solid <= 24'h0;
    end else if (w_pix_ce && w_origin) begin
      r_mode  <= mode;
      r_solid <= solid_rgb;
    end
  end

  // With no read latency the output register samples pixel (0,0) on the very
  // tick that latches the new mode, so that one pixel bypasses the latch.
  logic [1:0]  w_mode_sel;
  logic [23:0] w_solid_sel;
  logic [2:0]  w_bar;
  logic [23:0] w_rgb;

  assign w_mode_sel  = ((RD_LAT == 0) && w_origin) ? mode : r_mode;
  assign w_solid_sel = ((RD_LAT == 0) && w_origin) ? solid_rgb : r_solid;
  assign w_bar       = 3'((32'(w_d_h) * 32'd8) / 32'(H_ACTIVE));

  always_comb begin
    w_rgb = 24'h0;
    case (w_mode_sel)
      2'd0: w_rgb = rd_data;
      2'd1: begin
        case (w_bar)
          3'd0:    w_rgb = 24'hFFFFFF;
          3'd1:    w_rgb = 24'hFFFF00;
          3'd2:    w_rgb = 24'h00FFFF;
          3'd3:    w_rgb = 24'h00FF00;
          3'd4:    w_rgb = 24'hFF00FF;
          3'd5:    w_rgb = 24'hFF0000;
          3'd6:    w_rgb = 24'h0000FF;
          default: w_rgb = 24'h000000;
        endcase
      end
      2'd2:    w_rgb = w_solid_sel;
      default: w_rgb = ((w_d_h[3:0] == 4'd0) || (w_d_v[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      valid       <= 1'b0;
      vga_r       <= 8'h0;
      vga_g       <= 8'h0;
      vga_b       <= 8'h0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      if (w_pix_ce) begin
        hsync                 <= w_d_hs ? HS_POL : ~HS_POL;
        vsync                 <= w_d_vs ? VS_POL : ~VS_POL;
        valid                 <= w_d_act;
        {vga_r, vga_g, vga_b} <= w_d_act ? w_rgb : 24'h0;
        frame_start           <= w_d_act && (w_d_h == '0) && (w_d_v == '0);
        line_start            <= w_d_act && (w_d_h == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen using a reduced raster
//            (80x22 totals). A reference model pushes the expected output of
//            every pixel as the raster advances; a consumer pops and compares.
//            Feature tasks add targeted checks. A second instance exercises
//            CLK_DIV=4, en pausing and inverted sync polarity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4, HT = HA + HFP + HSY + HBP;
  localparam int VA = 16, VFP = 2, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
  localparam int LAT   = 2;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic        ls;
    logic [23:0] rgb;
  } exp_t;

  localparam exp_t IDLE = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en_a = 1'b1;
  logic        en_b = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = 24'h0;

  logic [9:0]  h_addr, v_addr, h_addr_b, v_addr_b;
  logic [23:0] rd_data, mem1, mem2;
  logic        hsync, vsync, valid, frame_start, line_start;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        hsync_b, vsync_b, valid_b, frame_start_b, line_start_b;
  logic [7:0]  vga_r_b, vga_g_b, vga_b_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(LAT), .CLK_DIV(1), .AW(10)
  ) dut (
    .clk(clk), .rst(rst_n), .en(en_a), .mode(mode), .solid_rgb(solid_rgb),
    .h_addr(h_addr), .v_addr(v_addr), .rd_data(rd_data),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .line_start(line_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(1), .CLK_DIV(4), .AW(10)
  ) dut4 (
    .clk(clk), .rst(rst_n), .en(en_b), .mode(mode), .solid_rgb(solid_rgb),
    .h_addr(h_addr_b), .v_addr(v_addr_b), .rd_data(24'h0),
    .hsync(hsync_b), .vsync(vsync_b), .valid(valid_b),
    .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
    .frame_start(frame_start_b), .line_start(line_start_b)
  );

  // Pixel memory with a two-tick read latency.
  always @(posedge clk) begin
    mem1 <= {h_addr[7:0], v_addr[7:0], 8'h5A};
    mem2 <= mem1;
  end
  assign rd_data = mem2 ^ {8'h0, 6'h0, h_addr[9:8] & 2'b00, 8'h0};

  // ---------------- reference model and scoreboard (main instance) --------
  exp_t        sb_q[$];
  exp_t        m_e;
  exp_t        c_e;
  int          m_h, m_v;
  logic [1:0]  m_mode;
  logic [23:0] m_solid;

  function automatic logic [23:0] bar_col(input int b);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_mode = 2'd0; m_solid = 24'h0;
      sb_q.delete();
      for (int i = 0; i < LAT; i++) sb_q.push_back(IDLE);
    end else begin
      if (m_h == 0 && m_v == 0) begin
        m_mode  = mode;
        m_solid = solid_rgb;
      end
      m_e.act = (m_h < HA) && (m_v < VA);
      m_e.hs  = !((m_h >= HA + HFP) && (m_h < HA + HFP + HSY));
      m_e.vs  = !((m_v >= VA + VFP) && (m_v < VA + VFP + VSY));
      m_e.fs  = m_e.act && (m_h == 0) && (m_v == 0);
      m_e.ls  = m_e.act && (m_h == 0);
      m_e.rgb = 24'h0;
      if (m_e.act) begin
        case (m_mode)
          2'd0: m_e.rgb = {8'(m_h), 8'(m_v), 8'h5A};
          2'd1: m_e.rgb = bar_col(m_h / 8);
          2'd2: m_e.rgb = m_solid;
          default: m_e.rgb = ((m_h % 16 == 0) || (m_v % 16 == 0)) ? 24'hFFFFFF : 24'h0;
        endcase
      end
      sb_q.push_back(m_e);
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && sb_q.size() > LAT) begin
      c_e = sb_q.pop_front();
      n_checks++;
      if ({hsync, vsync, valid, frame_start, line_start, vga_r, vga_g, vga_b} !== c_e) begin
        n_errors++;
        $display("FAIL sb_pixel t=%0t got hs=%b vs=%b v=%b fs=%b ls=%b rgb=%h exp hs=%b vs=%b v=%b fs=%b ls=%b rgb=%h",
                 $time, hsync, vsync, valid, frame_start, line_start, {vga_r, vga_g, vga_b},
                 c_e.hs, c_e.vs, c_e.act, c_e.fs, c_e.ls, c_e.rgb);
      end
    end
  end

  // ---------------- model of the CLK_DIV=4 instance's counters -----------
  int b_div, b_h, b_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_div = 0; b_h = 0; b_v = 0;
    end else if (en_b) begin
      if (b_div == 3) begin
        b_div = 0;
        b_h++;
        if (b_h == HT) begin
          b_h = 0;
          b_v++;
          if (b_v == VT) b_v = 0;
        end
      end else begin
        b_div++;
      end
    end
  end

  // Bounded wait for the next frame_start pulse (sampled on negedge).
  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3 * FRAME; t++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- feature tasks ---------------------------------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({hsync, vsync, valid, frame_start, line_start, vga_r, vga_g, vga_b} !== {5'b11000, 24'h0}) begin
      n_errors++;
      $display("FAIL reset_outputs got=%h exp=%h", {hsync, vsync, valid, frame_start, line_start, vga_r, vga_g, vga_b}, {5'b11000, 24'h0});
    end
    n_checks++;
    if ({h_addr, v_addr} !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_addr got=(%0d,%0d) exp=(0,0)", h_addr, v_addr);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hsync_b, vsync_b, valid_b, frame_start_b, line_start_b, vga_r_b, vga_g_b, vga_b_b, h_addr_b, v_addr_b} !== {5'b00000, 24'h0, 20'h0}) begin
      n_errors++;
      $display("FAIL reset_pol_inst got hs=%b vs=%b v=%b rgb=%h addr=(%0d,%0d) exp hs=0 vs=0 v=0 rgb=0 addr=(0,0)",
               hsync_b, vsync_b, valid_b, {vga_r_b, vga_g_b, vga_b_b}, h_addr_b, v_addr_b);
    end
    n_checks++;
    if ({hsync, vsync, valid} !== 3'b110) begin
      n_errors++;
      $display("FAIL reset_held got=%b exp=110", {hsync, vsync, valid});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frame_timing();
    bit ok;
    int cnt, w;
    wait_fs(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL frame_start_seen got=0 exp=1"); end
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!frame_start && cnt < 2 * FRAME);
    n_checks++;
    if (cnt != FRAME) begin n_errors++; $display("FAIL frame_period got=%0d exp=%0d", cnt, FRAME); end
    cnt = 0;
    while (hsync !== 1'b0 && cnt < HT) begin @(negedge clk); cnt++; end
    n_checks++;
    if (cnt != HA + HFP) begin n_errors++; $display("FAIL hsync_start got=%0d exp=%0d", cnt, HA + HFP); end
    w = 0;
    while (hsync === 1'b0 && w < HT) begin @(negedge clk); w++; end
    n_checks++;
    if (w != HSY) begin n_errors++; $display("FAIL hsync_width got=%0d exp=%0d", w, HSY); end
    cnt = 0;
    while (vsync !== 1'b0 && cnt < FRAME) begin @(negedge clk); cnt++; end
    w = 0;
    while (vsync === 1'b0 && w < FRAME) begin @(negedge clk); w++; end
    n_checks++;
    if (w != VSY * HT) begin n_errors++; $display("FAIL vsync_width got=%0d exp=%0d", w, VSY * HT); end
  endtask

  task automatic test_memory_mode();
    bit ok;
    @(negedge clk) mode = 2'd0;
    wait_fs(ok);
    wait_fs(ok);
    repeat (3 * HT) @(negedge clk);
    n_checks++;
    if ({valid, vga_r, vga_g, vga_b} !== {1'b1, 8'd0, 8'd3, 8'h5A}) begin
      n_errors++; $display("FAIL mem_px0 got=%b/%h exp=1/00035a", valid, {vga_r, vga_g, vga_b});
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if ({valid, vga_r, vga_g, vga_b} !== {1'b1, 8'd10, 8'd3, 8'h5A}) begin
      n_errors++; $display("FAIL mem_px10 got=%b/%h exp=1/0a035a", valid, {vga_r, vga_g, vga_b});
    end
    repeat (53) @(negedge clk);
    n_checks++;
    if ({valid, vga_r, vga_g, vga_b} !== {1'b1, 8'd63, 8'd3, 8'h5A}) begin
      n_errors++; $display("FAIL mem_px63 got=%b/%h exp=1/3f035a", valid, {vga_r, vga_g, vga_b});
    end
    @(negedge clk);
    n_checks++;
    if ({valid, vga_r, vga_g, vga_b} !== 25'h0) begin
      n_errors++; $display("FAIL mem_px64_blank got=%b/%h exp=0/000000", valid, {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_colour_bars();
    bit ok;
    int hpos[7]       = '{0, 7, 8, 16, 55, 56, 64};
    logic [24:0] e[7] = '{{1'b1, 24'hFFFFFF}, {1'b1, 24'hFFFFFF}, {1'b1, 24'hFFFF00},
                          {1'b1, 24'h00FFFF}, {1'b1, 24'h0000FF}, {1'b1, 24'h000000},
                          {1'b0, 24'h000000}};
    int cur;
    @(negedge clk) mode = 2'd1;
    wait_fs(ok);
    wait_fs(ok);
    cur = 0;
    for (int i = 0; i < 7; i++) begin
      repeat (hpos[i] - cur) @(negedge clk);
      cur = hpos[i];
      n_checks++;
      if ({valid, vga_r, vga_g, vga_b} !== e[i]) begin
        n_errors++;
        $display("FAIL bars_h%0d got=%b/%h exp=%b/%h", hpos[i], valid, {vga_r, vga_g, vga_b}, e[i][24], e[i][23:0]);
      end
    end
  endtask

  task automatic test_mode_switch();
    bit ok;
    wait_fs(ok);
    repeat (8 * HT) @(negedge clk);
    mode = 2'd2;
    solid_rgb = 24'h123456;
    repeat (2 * HT + 20) @(negedge clk);
    n_checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h00FFFF) begin
      n_errors++; $display("FAIL switch_same_frame got=%h exp=00ffff", {vga_r, vga_g, vga_b});
    end
    wait_fs(ok);
    n_checks++;
    if ({valid, vga_r, vga_g, vga_b} !== {1'b1, 24'h123456}) begin
      n_errors++; $display("FAIL switch_next_px0 got=%b/%h exp=1/123456", valid, {vga_r, vga_g, vga_b});
    end
    repeat (15 * HT + 63) @(negedge clk);
    n_checks++;
    if ({valid, vga_r, vga_g, vga_b} !== {1'b1, 24'h123456}) begin
      n_errors++; $display("FAIL switch_next_last got=%b/%h exp=1/123456", valid, {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_grid();
    bit ok;
    @(negedge clk) mode = 2'd3;
    wait_fs(ok);
    wait_fs(ok);
    repeat (HT + 1) @(negedge clk);
    n_checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      n_errors++; $display("FAIL grid_1_1 got=%h exp=000000", {vga_r, vga_g, vga_b});
    end
    repeat (15) @(negedge clk);
    n_checks++;
    if ({vga_r, vga_g, vga_b} !== 24'hFFFFFF) begin
      n_errors++; $display("FAIL grid_16_1 got=%h exp=ffffff", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_clk_div_enable();
    int off_cnt;
    bit toggled;
    logic [9:0] eh, ev;
    off_cnt = 0;
    toggled = 1'b0;
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk);
      eh = (en_b && b_h < HA && b_v < VA) ? 10'(b_h) : 10'd0;
      ev = (en_b && b_h < HA && b_v < VA) ? 10'(b_v) : 10'd0;
      n_checks++;
      if (h_addr_b !== eh || v_addr_b !== ev) begin
        n_errors++;
        $display("FAIL clk_div_addr t=%0t got=(%0d,%0d) exp=(%0d,%0d)", $time, h_addr_b, v_addr_b, eh, ev);
      end
      if (off_cnt > 0) begin
        off_cnt--;
        if (off_cnt == 0) en_b = 1'b1;
      end else if (!toggled && b_h == 20 && b_div == 1 && b_v < VA) begin
        en_b = 1'b0;
        off_cnt = 10;
        toggled = 1'b1;
      end
    end
    n_checks++;
    if (toggled !== 1'b1 || en_b !== 1'b1) begin
      n_errors++; $display("FAIL clk_div_pause_done got=%b%b exp=11", toggled, en_b);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int k;
    wait_fs(ok);
    repeat (8 * HT + 70) @(negedge clk);
    n_checks++;
    if (hsync !== 1'b0) begin n_errors++; $display("FAIL midframe_in_sync got=%b exp=0", hsync); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({hsync, vsync, valid, frame_start, line_start, vga_r, vga_g, vga_b, h_addr, v_addr} !== {5'b11000, 24'h0, 20'h0}) begin
      n_errors++;
      $display("FAIL midframe_async_idle got hs=%b vs=%b v=%b rgb=%h addr=(%0d,%0d) exp hs=1 vs=1 v=0 rgb=0 addr=(0,0)",
               hsync, vsync, valid, {vga_r, vga_g, vga_b}, h_addr, v_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (frame_start) begin
        k = i;
        break;
      end
    end
    n_checks++;
    if (k != 1 + LAT) begin n_errors++; $display("FAIL restart_latency got=%0d exp=%0d", k, 1 + LAT); end
    repeat (2 * HT) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_memory_mode();
    test_colour_bars();
    test_mode_switch();
    test_grid();
    test_clk_div_enable();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- HS_POL / VS_POL, 0 / 0, asserted level of hsync / vsync
- RD_LAT, 1, pixel-memory read latency in pixel ticks (0..4)
- CLK_DIV, 1, clk cycles per pixel tick (1..8)
- AW, 10, width of h_addr and v_addr
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock
- rst, in, 1, asynchronous active-low reset
- en, in, 1, timing enable
- mode, in, 2, 0 memory, 1 colour bars, 2 solid colour, 3 grid
- solid_rgb, in, 24, colour used in mode 2
- h_addr / v_addr, out, AW, pixel coordinate presented to the pixel memory
- rd_data, in, 24, pixel data {R,G,B}, valid RD_LAT ticks after its address
- hsync / vsync / valid, out, 1, sync outputs and active-video (blank_n)
- vga_r / vga_g / vga_b, out, 8, colour outputs
- frame_start / line_start, out, 1, one-clk pulses aligned to the first active pixel of the frame / line

Function
REQ-003 SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL likewise (525).
REQ-004 SHALL generate pix_ce every CLK_DIV clk cycles from a divider counter; CLK_DIV=1 gives pix_ce constantly high.
REQ-005 SHALL advance h_cnt on pix_ce, wrapping from H_TOTAL-1 to 0; v_cnt SHALL increment only on that wrap and SHALL itself wrap from V_TOTAL-1 to 0 on the same tick.
REQ-006 SHALL hold the divider, h_cnt and v_cnt when en=0; the raw active signal SHALL be forced to 0 while en=0.
REQ-007 SHALL define raw active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE); h_addr/v_addr SHALL equal h_cnt/v_cnt when raw active, else 0.
REQ-008 SHALL assert raw hsync (level HS_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and raw vsync (level VS_POL) for v_cnt in the equivalent vertical range.
REQ-009 SHALL delay raw hsync, vsync, active, h_cnt and v_cnt by exactly RD_LAT pix_ce stages so all outputs align with rd_data; RD_LAT=0 SHALL be a pure combinational pass from the counters.
REQ-010 SHALL latch mode and solid_rgb only when the counters are at (0,0) on pix_ce; changes mid-frame SHALL take effect at the next frame.
REQ-011 SHALL drive colour from the latched mode using the delayed coordinates: 0 = rd_data; 1 = eight equal vertical bars selected by floor(h*8/H_ACTIVE), order white, yellow, cyan, green, magenta, red, blue, black; 2 = latched solid_rgb; 3 = white where h[3:0]==0 or v[3:0]==0, otherwise black.
REQ-012 SHALL force vga_r/g/b to 0 whenever valid=0.
REQ-013 SHALL register hsync, vsync, valid and colour outputs on clk, updating only on pix_ce.
REQ-014 SHALL pulse frame_start for one clk when the delayed coordinate reaches (0,0) with valid rising, and line_start for one clk at the delayed coordinate (0,v) for each v<V_ACTIVE.

Reset
REQ-015 SHALL, on rst=0 (asynchronous), clear divider, h_cnt, v_cnt, all delay stages and latched mode (to 0); outputs SHALL be hsync=~HS_POL, vsync=~VS_POL, valid=0, colour=0, pulses=0, h_addr=v_addr=0.
REQ-016 SHALL resume after reset deassertion with h_cnt=0, v_cnt=0, so the first pix_ce presents pixel (0,0); reset mid-frame SHALL abandon the frame with no partial sync pulse extension.

Verification
REQ-017 Defaults, en=1, count clks for one frame -> 420000 clks between frame_start pulses; hsync low for 96 ticks starting 656 ticks after line start; vsync low for 2 lines.
REQ-018 Mode 0, RD_LAT=2, memory model returning {h_addr[7:0],v_addr[7:0],8'h5A} -> pixel (10,3) appears on output as r=10, g=3, b=0x5A with valid=1, no off-by-one at h=0 or h=639.
REQ-019 Mode 1 -> h=0..79 white 0xFFFFFF, h=80 yellow 0xFFFF00, h=560..639 black; h=640 colour 0 with valid=0.
REQ-020 CLK_DIV=4, en toggled low for 10 clks mid-line -> h_cnt frozen, no extra or missing pixels, each pixel held exactly 4 clks when en=1.
REQ-021 Mode switched 1->2 at line 100 with solid_rgb=0x123456 -> remainder of frame stays colour bars; next frame all active pixels 0x123456.
REQ-022 rst pulsed low at h=700,v=200 mid-hsync -> outputs at idle values immediately (asynchronously); after release, first frame_start occurs after 1 tick plus RD_LAT ticks.
